// File: rtl/sevenseg_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_capture_if
// Purpose  : Bundles the multiplexed display bus and the reassembled-frame
//            outputs of sevenseg_capture.
// Ports    : seg   - {digit selects (active-low), dp,g,f,e,d,c,b,a (active-low)}
//            value - decoded nibbles, cell k in value[4k+3:4k]
//            dp    - decimal point per cell, 1 = lit
//            blank - cell had all seven segments off
//            err   - cell pattern was not a legal glyph nor blank
//            valid - one-cycle frame-complete pulse
//            master: drives seg, observes results; slave: the capture block
// Revision : 1.0 - initial release
// ============================================================================
interface sevenseg_capture_if #(
  parameter int NUMCELLS = 4
);
  logic [7+NUMCELLS:0]    seg;
  logic [4*NUMCELLS-1:0]  value;
  logic [NUMCELLS-1:0]    dp;
  logic [NUMCELLS-1:0]    blank;
  logic [NUMCELLS-1:0]    err;
  logic                   valid;

  modport master (output seg, input value, dp, blank, err, valid);
  modport slave  (input seg, output value, dp, blank, err, valid);
endinterface
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_capture
// Purpose  : Samples a multiplexed seven-segment display bus, captures each
//            digit once it has been stable for STABLE_CYCLES edges, decodes
//            the glyph back to a hex nibble and, once all cells are seen,
//            presents the reassembled frame with a one-cycle valid pulse.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            bus  - sevenseg_capture_if slave (seg in; value/dp/blank/err/valid out)
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_capture #(
  parameter int NUMCELLS      = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_capture_if.slave bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);
  localparam logic [0:0] c_HUNT   = 1'b0;
  localparam logic [0:0] c_HELD   = 1'b1;

  logic [7+NUMCELLS:0]   r_s_q;
  logic [7:0]            r_cnt;
  logic [0:0]            r_state;
  logic [NUMCELLS-1:0]   r_seen;
  logic [4*NUMCELLS-1:0] r_sh_val;
  logic [NUMCELLS-1:0]   r_sh_dp;
  logic [NUMCELLS-1:0]   r_sh_blank;
  logic [NUMCELLS-1:0]   r_sh_err;
  logic [4*NUMCELLS-1:0] r_value;
  logic [NUMCELLS-1:0]   r_dp;
  logic [NUMCELLS-1:0]   r_blank;
  logic [NUMCELLS-1:0]   r_err;
  logic                  r_valid;

  logic                  w_change;
  logic [7:0]            w_cnt_next;
  logic [NUMCELLS-1:0]   w_sel;
  logic                  w_qual;
  logic                  w_capture;
  logic                  w_complete;
  logic [6:0]            w_segs;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_err;
  logic [4*NUMCELLS-1:0] w_sh_val_n;
  logic [NUMCELLS-1:0]   w_sh_dp_n;
  logic [NUMCELLS-1:0]   w_sh_blank_n;
  logic [NUMCELLS-1:0]   w_sh_err_n;
  logic [NUMCELLS-1:0]   w_seen_n;

  assign w_change   = (bus.seg != r_s_q);
  assign w_cnt_next = w_change ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);

  // Qualified only when exactly one select line is pulled low.
  assign w_sel  = ~bus.seg[8 +: NUMCELLS];
  assign w_qual = (w_sel != '0) && ((w_sel & (w_sel - NUMCELLS'(1))) == '0);

  // A change edge counts as hunting even from HELD, so STABLE_CYCLES = 1
  // captures a new pattern on its very first edge.
  assign w_capture = ((r_state == c_HUNT) || w_change) && (w_cnt_next == c_STABLE) && w_qual;

  assign w_segs = ~bus.seg[6:0];

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_err   = 1'b0;
    case (w_segs)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      7'h00: w_blank = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // Shadow contents including this edge's capture, so a completing capture
  // lands in the published frame.
  always_comb begin
    w_sh_val_n   = r_sh_val;
    w_sh_dp_n    = r_sh_dp;
    w_sh_blank_n = r_sh_blank;
    w_sh_err_n   = r_sh_err;
    w_seen_n     = r_seen;
    for (int k = 0; k < NUMCELLS; k++) begin
      if (w_capture && w_sel[k]) begin
        w_sh_val_n[4*k +: 4] = w_nib;
        w_sh_dp_n[k]         = ~bus.seg[7];
        w_sh_blank_n[k]      = w_blank;
        w_sh_err_n[k]        = w_err;
        w_seen_n[k]          = 1'b1;
      end
    end
  end

  assign w_complete = w_capture && (w_seen_n == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q      <= '1;
      r_cnt      <= 8'd0;
      r_state    <= c_HUNT;
      r_seen     <= '0;
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
      r_value    <= '0;
      r_dp       <= '0;
      r_blank    <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_s_q   <= bus.seg;
      r_cnt   <= w_cnt_next;
      r_valid <= w_complete;
      if (w_capture) begin
        r_state <= c_HELD;
      end else if (w_change) begin
        r_state <= c_HUNT;
      end
      if (w_capture) begin
        r_sh_val   <= w_sh_val_n;
        r_sh_dp    <= w_sh_dp_n;
        r_sh_blank <= w_sh_blank_n;
        r_sh_err   <= w_sh_err_n;
        r_seen     <= w_complete ? '0 : w_seen_n;
      end
      if (w_complete) begin
        r_value <= w_sh_val_n;
        r_dp    <= w_sh_dp_n;
        r_blank <= w_sh_blank_n;
        r_err   <= w_sh_err_n;
      end
    end
  end

  assign bus.value = r_value;
  assign bus.dp    = r_dp;
  assign bus.blank = r_blank;
  assign bus.err   = r_err;
  assign bus.valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_capture
// Purpose  : Self-checking bench for sevenseg_capture (STABLE_CYCLES = 4).
//            A dwell-level reference model tracks how long each bus pattern
//            has been present and reassembles frames from glyph lookups.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_capture_if #(.NUMCELLS(4)) bus ();

  sevenseg_capture #(.NUMCELLS(4), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_vec   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  // reference model state
  logic [11:0] m_prev;
  int          m_run;
  logic [3:0]  m_nib [4];
  logic        m_dp [4];
  logic        m_bl [4];
  logic        m_er [4];
  logic        m_seen [4];
  logic [15:0] e_value;
  logic [3:0]  e_dp, e_blank, e_err;
  logic        e_valid;

  task automatic model_reset();
    m_prev = 12'hFFF;
    m_run  = 0;
    for (int k = 0; k < 4; k++) begin
      m_nib[k] = 4'h0; m_dp[k] = 1'b0; m_bl[k] = 1'b0; m_er[k] = 1'b0; m_seen[k] = 1'b0;
    end
    e_value = '0; e_dp = '0; e_blank = '0; e_err = '0; e_valid = 1'b0;
  endtask

  task automatic model_step(input logic [11:0] s);
    int   k;
    int   hit;
    logic all;
    logic [6:0] g;
    if (s == m_prev) m_run++;
    else begin
      m_run  = 1;
      m_prev = s;
    end
    e_valid = 1'b0;
    if (m_run == S && $countones(~s[11:8]) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!s[8+i]) k = i;
      g   = ~s[6:0];
      hit = -1;
      for (int i = 0; i < 16; i++) if (GLYPH[i] == g) hit = i;
      m_nib[k]  = (hit >= 0) ? 4'(hit) : 4'h0;
      m_bl[k]   = (g == 7'h00);
      m_er[k]   = (hit < 0) && (g != 7'h00);
      m_dp[k]   = ~s[7];
      m_seen[k] = 1'b1;
      all = m_seen[0] & m_seen[1] & m_seen[2] & m_seen[3];
      if (all) begin
        for (int i = 0; i < 4; i++) begin
          e_value[4*i +: 4] = m_nib[i];
          e_dp[i]    = m_dp[i];
          e_blank[i] = m_bl[i];
          e_err[i]   = m_er[i];
          m_seen[i]  = 1'b0;
        end
        e_valid = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag);
    n_vec++;
    assert (bus.valid === e_valid) else begin
      n_err++; $error("FAIL %s valid: observed %b expected %b", tag, bus.valid, e_valid);
    end
    n_vec++;
    assert (bus.value === e_value) else begin
      n_err++; $error("FAIL %s value: observed %h expected %h", tag, bus.value, e_value);
    end
    n_vec++;
    assert ({bus.dp, bus.blank, bus.err} === {e_dp, e_blank, e_err}) else begin
      n_err++; $error("FAIL %s dp/blank/err: observed %b/%b/%b expected %b/%b/%b",
                      tag, bus.dp, bus.blank, bus.err, e_dp, e_blank, e_err);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] sg, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      bus.seg = {sel, sg};
      @(posedge clk);
      model_step({sel, sg});
      #1;
      if (bus.valid === 1'b1) n_pulse++;
      check(tag);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    check("reset");
    rst = 1'b0;
  endtask

  function automatic logic [3:0] cell_sel(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  function automatic logic [7:0] glyph_seg(input int d);
    return {1'b1, ~GLYPH[d]};
  endfunction

  task automatic basic_frame(input bit glitches, input string tag);
    for (int k = 0; k < 4; k++) begin
      drive(cell_sel(k), glyph_seg(k + 1), 10, tag);
      if (glitches) begin
        drive(4'h0, glyph_seg(8), 6, tag);
        drive(4'hF, glyph_seg(5), 6, tag);
      end
    end
  endtask

  initial begin
    bus.seg = 12'hFFF;
    do_reset(2);

    // basic frame: 1,2,3,4 in cells 0..3
    n_pulse = 0;
    basic_frame(1'b0, "basic");
    n_vec++;
    assert (bus.value === 16'h4321 && n_pulse === 1) else begin
      n_err++; $error("FAIL basic_result: observed value %h pulses %0d expected 4321/1", bus.value, n_pulse);
    end

    // short dwell rejection on cell 2
    n_pulse = 0;
    drive(cell_sel(0), glyph_seg(5), 10, "short");
    drive(cell_sel(1), glyph_seg(6), 10, "short");
    drive(cell_sel(2), glyph_seg(7), S - 1, "short");
    drive(cell_sel(3), glyph_seg(8), 10, "short");
    n_vec++;
    assert (n_pulse === 0) else begin
      n_err++; $error("FAIL short_no_valid: observed %0d pulses expected 0", n_pulse);
    end
    drive(cell_sel(2), glyph_seg(7), 10, "short");
    n_vec++;
    assert (n_pulse === 1 && bus.value === 16'h8765) else begin
      n_err++; $error("FAIL short_complete: observed %0d pulses value %h expected 1/8765", n_pulse, bus.value);
    end

    // glyph coverage through cell 0 (16 glyphs, blank, illegal, all-lit with dp)
    for (int g = 0; g < 19; g++) begin
      logic [7:0] pat;
      if (g < 16)       pat = glyph_seg(g);
      else if (g == 16) pat = 8'hFF;
      else if (g == 17) pat = ~8'h49;
      else              pat = 8'h00;
      drive(cell_sel(1), glyph_seg(0), 6, "glyph");
      drive(cell_sel(2), glyph_seg(0), 6, "glyph");
      drive(cell_sel(3), glyph_seg(0), 6, "glyph");
      drive(cell_sel(0), pat, 6, "glyph");
      if (g < 16) begin
        n_vec++;
        assert (bus.value[3:0] === 4'(g) && bus.err[0] === 1'b0) else begin
          n_err++; $error("FAIL glyph_decode: observed %h err %b expected %h err 0", bus.value[3:0], bus.err[0], 4'(g));
        end
      end else if (g == 16) begin
        n_vec++;
        assert (bus.blank[0] === 1'b1 && bus.err[0] === 1'b0) else begin
          n_err++; $error("FAIL glyph_blank: observed blank %b err %b expected 1/0", bus.blank[0], bus.err[0]);
        end
      end else if (g == 17) begin
        n_vec++;
        assert (bus.err[0] === 1'b1 && bus.blank[0] === 1'b0) else begin
          n_err++; $error("FAIL glyph_illegal: observed err %b blank %b expected 1/0", bus.err[0], bus.blank[0]);
        end
      end else begin
        n_vec++;
        assert (bus.dp[0] === 1'b1 && bus.value[3:0] === 4'h8) else begin
          n_err++; $error("FAIL glyph_dp: observed dp %b nib %h expected 1/8", bus.dp[0], bus.value[3:0]);
        end
      end
    end

    // select glitches interleaved with the basic frame
    n_pulse = 0;
    basic_frame(1'b1, "glitch");
    n_vec++;
    assert (bus.value === 16'h4321 && n_pulse === 1 && bus.err === 4'h0) else begin
      n_err++; $error("FAIL glitch_result: observed value %h pulses %0d err %b expected 4321/1/0", bus.value, n_pulse, bus.err);
    end

    // long dwell on cell 1
    n_pulse = 0;
    drive(cell_sel(1), glyph_seg(9), 500, "long");
    n_vec++;
    assert (dut.r_cnt === 8'd255 && n_pulse === 0) else begin
      n_err++; $error("FAIL long_dwell: observed cnt %0d pulses %0d expected 255/0", dut.r_cnt, n_pulse);
    end
    drive(cell_sel(0), glyph_seg(10), 8, "long");
    drive(cell_sel(2), glyph_seg(11), 8, "long");
    drive(cell_sel(3), glyph_seg(12), 8, "long");

    // reset mid-frame
    n_pulse = 0;
    drive(cell_sel(0), glyph_seg(1), 10, "rstmid");
    drive(cell_sel(1), glyph_seg(2), 10, "rstmid");
    drive(cell_sel(2), glyph_seg(3), 10, "rstmid");
    do_reset(1);
    drive(cell_sel(3), glyph_seg(4), 10, "rstmid");
    n_vec++;
    assert (n_pulse === 0 && bus.value === 16'h0000) else begin
      n_err++; $error("FAIL rstmid: observed pulses %0d value %h expected 0/0000", n_pulse, bus.value);
    end
    basic_frame(1'b0, "rstmid");

    // randomized dwells
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [3:0] sel;
      logic [7:0] pat;
      r = int'($urandom_range(0, 5));
      if (r < 4)       sel = cell_sel(r);
      else if (r == 4) sel = 4'(4'h0 | ($urandom_range(0, 1) != 0 ? 4'h3 : 4'h0));
      else             sel = 4'hF;
      r = int'($urandom_range(0, 19));
      if (r < 16)       pat = glyph_seg(r);
      else if (r == 16) pat = 8'hFF;
      else              pat = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pat[7] = 1'b0;
      drive(sel, pat, int'($urandom_range(1, 7)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
